// File: rtl/lenet_layer_scheduler.sv
// Runs the LeNet-5 layer engines one at a time (mask-selectable) and steers the active engine onto the shared BRAM ports.
// Latency: start -> layer_en two edges; finish -> next layer_en after GAP_CYCLES+1 edges; the BRAM mux is combinational.
// Backpressure: none; engines pace themselves with layer_en/layer_finish, while abort and the watchdog force a return to idle.

module lenet_layer_scheduler #(
    parameter int          NUM_LAYERS     = 7,
    parameter int          DATA_SIZE      = 16,
    parameter int          BW_AW          = 16,
    parameter int          RES_AW         = 13,
    parameter int          GAP_CYCLES     = 2,
    parameter int          MIN_DWELL      = 2,
    parameter int unsigned TIMEOUT_CYCLES = 32'd16777216,
    localparam int         LW             = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start,
    input  logic                            abort,
    input  logic [NUM_LAYERS-1:0]           layer_mask,
    input  logic [NUM_LAYERS-1:0]           layer_finish,
    input  logic [NUM_LAYERS-1:0]           lyr_bw_ena,
    input  logic [NUM_LAYERS*BW_AW-1:0]     lyr_bw_addra,
    input  logic [NUM_LAYERS-1:0]           lyr_res_ena,
    input  logic [NUM_LAYERS-1:0]           lyr_res_wea,
    input  logic [NUM_LAYERS*RES_AW-1:0]    lyr_res_addra,
    input  logic [NUM_LAYERS*DATA_SIZE-1:0] lyr_res_dina,
    output logic [NUM_LAYERS-1:0]           layer_en,
    output logic                            bias_weights_bram_ena,
    output logic [BW_AW-1:0]                bias_weights_bram_addra,
    output logic                            result_bram_ena,
    output logic                            result_bram_wea,
    output logic [RES_AW-1:0]               result_bram_addra,
    output logic [DATA_SIZE-1:0]            result_bram_dina,
    output logic                            busy,
    output logic                            done,
    output logic                            timeout,
    output logic [LW-1:0]                   cur_layer
);

    localparam int DW = $clog2(MIN_DWELL + 2);
    localparam int GW = $clog2(GAP_CYCLES + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_GAP  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t                 state_q;
    state_t                 state_d;
    logic [NUM_LAYERS-1:0]  mask_q;
    logic [DW-1:0]          dwell_cnt;
    logic [GW-1:0]          gap_cnt;
    logic [31:0]            run_cnt;

    logic [LW-1:0]          first_idx;
    logic                   first_vld;
    logic [LW-1:0]          next_idx;
    logic                   next_vld;
    logic                   cur_finish;
    logic [NUM_LAYERS-1:0]  en_onehot;
    logic                   dwell_ok;
    logic                   gap_expired;
    logic                   wd_hit;
    logic                   accept_start;
    logic                   advance;
    logic                   wd_fire;

    // First layer to run comes straight from the incoming mask, since mask_q is loaded on the same edge
    always_comb begin
        first_vld = 1'b0;
        first_idx = '0;
        for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
            if (layer_mask[i]) begin
                first_vld = 1'b1;
                first_idx = LW'(i);
            end
        end
    end

    // Next layer: lowest latched mask bit strictly above the current layer
    always_comb begin
        next_vld = 1'b0;
        next_idx = '0;
        for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
            if (mask_q[i] && (i > int'(cur_layer))) begin
                next_vld = 1'b1;
                next_idx = LW'(i);
            end
        end
    end

    // Decode the active layer: its finish flag and its one-hot enable pattern
    always_comb begin
        cur_finish = 1'b0;
        en_onehot  = '0;
        for (int i = 0; i < NUM_LAYERS; i++) begin
            if (cur_layer == LW'(i)) begin
                cur_finish   = layer_finish[i];
                en_onehot[i] = 1'b1;
            end
        end
    end

    // Finish is only trusted once the engine has been enabled for MIN_DWELL cycles
    assign dwell_ok    = (dwell_cnt == DW'(MIN_DWELL));
    assign gap_expired = (gap_cnt == GW'(GAP_CYCLES - 1));
    assign wd_hit      = (TIMEOUT_CYCLES != 0) && (run_cnt == 32'(TIMEOUT_CYCLES - 1));
    assign busy        = (state_q == S_RUN) || (state_q == S_GAP);

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and the per-edge strobes that drive the datapath; abort outranks everything
    always_comb begin
        state_d      = state_q;
        accept_start = 1'b0;
        advance      = 1'b0;
        wd_fire      = 1'b0;
        if (abort) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        accept_start = 1'b1;
                        state_d      = first_vld ? S_RUN : S_DONE;
                    end
                end
                S_RUN: begin
                    // A qualified finish beats a watchdog expiry on the same edge
                    if (dwell_ok && cur_finish) begin
                        state_d = S_GAP;
                    end else if (wd_hit) begin
                        wd_fire = 1'b1;
                        state_d = S_IDLE;
                    end
                end
                S_GAP: begin
                    if (gap_expired) begin
                        if (next_vld) begin
                            advance = 1'b1;
                            state_d = S_RUN;
                        end else begin
                            state_d = S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // Layer bookkeeping, dwell/gap/run counters and the registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mask_q    <= '0;
            cur_layer <= '0;
            dwell_cnt <= '0;
            gap_cnt   <= '0;
            run_cnt   <= '0;
            layer_en  <= '0;
            done      <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            if (accept_start) begin
                mask_q  <= layer_mask;
                timeout <= 1'b0;
                if (first_vld) begin
                    cur_layer <= first_idx;
                end
            end
            if (advance) begin
                cur_layer <= next_idx;
            end
            if (wd_fire) begin
                timeout <= 1'b1;
            end

            // Counters run only in their own state, so every entry into RUN/GAP starts from zero
            if (state_q == S_RUN) begin
                if (!dwell_ok) begin
                    dwell_cnt <= dwell_cnt + DW'(1);
                end
                run_cnt <= run_cnt + 32'd1;
            end else begin
                dwell_cnt <= '0;
                run_cnt   <= '0;
            end
            if (state_q == S_GAP) begin
                gap_cnt <= gap_cnt + GW'(1);
            end else begin
                gap_cnt <= '0;
            end

            // Enable trails the RUN state by one edge; abort and watchdog drop it at once
            layer_en <= ((state_q == S_RUN) && !abort && !wd_fire) ? en_onehot : '0;
            done     <= (state_q == S_DONE) && !abort;
        end
    end

    // Shared BRAM mux: only the running layer reaches the ports, everything else reads as zero
    always_comb begin
        bias_weights_bram_ena   = 1'b0;
        bias_weights_bram_addra = '0;
        result_bram_ena         = 1'b0;
        result_bram_wea         = 1'b0;
        result_bram_addra       = '0;
        result_bram_dina        = '0;
        if (state_q == S_RUN) begin
            for (int i = 0; i < NUM_LAYERS; i++) begin
                if (cur_layer == LW'(i)) begin
                    bias_weights_bram_ena   = lyr_bw_ena[i];
                    bias_weights_bram_addra = lyr_bw_addra[i*BW_AW +: BW_AW];
                    result_bram_ena         = lyr_res_ena[i];
                    result_bram_wea         = lyr_res_wea[i];
                    result_bram_addra       = lyr_res_addra[i*RES_AW +: RES_AW];
                    result_bram_dina        = lyr_res_dina[i*DATA_SIZE +: DATA_SIZE];
                end
            end
        end
    end

endmodule

// File: tb/tb_lenet_layer_scheduler.sv
// Randomised bench for lenet_layer_scheduler against a timeline model built from the layer timing rules.
// Latency: each scenario is open-loop; expected outputs per cycle are precomputed before driving.
// Backpressure: none; engine finish flags are scheduled from the model's expected enable times.

module tb_lenet_layer_scheduler;

    localparam int NL = 7;
    localparam int DS = 16;
    localparam int BW = 16;
    localparam int RW = 13;
    localparam int G  = 2;
    localparam int MD = 2;
    localparam int T  = 100;
    localparam int N  = 2048;
    localparam int NEVER = 9999;
    localparam int STALE = -1;
    localparam int RAND  = -2;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             start = 1'b0;
    logic             abort = 1'b0;
    logic [NL-1:0]    layer_mask = '0;
    logic [NL-1:0]    layer_finish = '0;
    logic [NL-1:0]    lyr_bw_ena = '0;
    logic [NL*BW-1:0] lyr_bw_addra = '0;
    logic [NL-1:0]    lyr_res_ena = '0;
    logic [NL-1:0]    lyr_res_wea = '0;
    logic [NL*RW-1:0] lyr_res_addra = '0;
    logic [NL*DS-1:0] lyr_res_dina = '0;
    logic [NL-1:0]    layer_en;
    logic             bias_weights_bram_ena;
    logic [BW-1:0]    bias_weights_bram_addra;
    logic             result_bram_ena;
    logic             result_bram_wea;
    logic [RW-1:0]    result_bram_addra;
    logic [DS-1:0]    result_bram_dina;
    logic             busy;
    logic             done;
    logic             timeout;
    logic [2:0]       cur_layer;

    lenet_layer_scheduler #(
        .NUM_LAYERS(NL), .DATA_SIZE(DS), .BW_AW(BW), .RES_AW(RW),
        .GAP_CYCLES(G), .MIN_DWELL(MD), .TIMEOUT_CYCLES(T)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .layer_mask(layer_mask), .layer_finish(layer_finish),
        .lyr_bw_ena(lyr_bw_ena), .lyr_bw_addra(lyr_bw_addra),
        .lyr_res_ena(lyr_res_ena), .lyr_res_wea(lyr_res_wea),
        .lyr_res_addra(lyr_res_addra), .lyr_res_dina(lyr_res_dina),
        .layer_en(layer_en),
        .bias_weights_bram_ena(bias_weights_bram_ena),
        .bias_weights_bram_addra(bias_weights_bram_addra),
        .result_bram_ena(result_bram_ena), .result_bram_wea(result_bram_wea),
        .result_bram_addra(result_bram_addra), .result_bram_dina(result_bram_dina),
        .busy(busy), .done(done), .timeout(timeout), .cur_layer(cur_layer)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Expected per-cycle timeline; cycle t is the interval after rising edge t of a scenario
    logic [NL-1:0] e_en   [N];
    bit            e_busy [N];
    bit            e_done [N];
    bit            e_to   [N];
    bit            e_run  [N];
    int            e_cur  [N];
    int            fin_st [NL];
    int            d_cfg  [NL];
    int            er_of  [NL];
    int            en_cnt [NL];
    int            model_cur = 0;
    bit            model_to  = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h at %0t", tag, got, want, $time);
        end
    endtask

    task automatic chk_zero(input string pfx);
        chk({pfx, "_en"},      32'(layer_en), 32'd0);
        chk({pfx, "_busy"},    32'(busy), 32'd0);
        chk({pfx, "_done"},    32'(done), 32'd0);
        chk({pfx, "_tmo"},     32'(timeout), 32'd0);
        chk({pfx, "_cur"},     32'(cur_layer), 32'd0);
        chk({pfx, "_bw_ena"},  32'(bias_weights_bram_ena), 32'd0);
        chk({pfx, "_bw_addr"}, 32'(bias_weights_bram_addra), 32'd0);
        chk({pfx, "_res_ena"}, 32'(result_bram_ena), 32'd0);
        chk({pfx, "_res_wea"}, 32'(result_bram_wea), 32'd0);
        chk({pfx, "_res_adr"}, 32'(result_bram_addra), 32'd0);
        chk({pfx, "_res_din"}, 32'(result_bram_dina), 32'd0);
    endtask

    task automatic chk_cycle(input int t);
        int c;
        logic [31:0] w_bwe, w_bwa, w_rse, w_rsw, w_rsa, w_rsd;
        c = e_cur[t];
        w_bwe = '0; w_bwa = '0; w_rse = '0; w_rsw = '0; w_rsa = '0; w_rsd = '0;
        if (e_run[t]) begin
            w_bwe = 32'(lyr_bw_ena[c]);
            w_bwa = 32'(lyr_bw_addra[c*BW +: BW]);
            w_rse = 32'(lyr_res_ena[c]);
            w_rsw = 32'(lyr_res_wea[c]);
            w_rsa = 32'(lyr_res_addra[c*RW +: RW]);
            w_rsd = 32'(lyr_res_dina[c*DS +: DS]);
        end
        chk("layer_en", 32'(layer_en), 32'(e_en[t]));
        chk("busy",     32'(busy), 32'(e_busy[t]));
        chk("done",     32'(done), 32'(e_done[t]));
        chk("timeout",  32'(timeout), 32'(e_to[t]));
        chk("cur",      32'(cur_layer), 32'(c));
        chk("bw_ena",   32'(bias_weights_bram_ena), w_bwe);
        chk("bw_addr",  32'(bias_weights_bram_addra), w_bwa);
        chk("res_ena",  32'(result_bram_ena), w_rse);
        chk("res_wea",  32'(result_bram_wea), w_rsw);
        chk("res_addr", 32'(result_bram_addra), w_rsa);
        chk("res_din",  32'(result_bram_dina), w_rsd);
    endtask

    // abort_sel: -1 none, -2 first cycle of the first gap, else absolute abort edge.
    // rst_layer: layer during whose run reset is pulsed (-1 none).
    task automatic run_scn(input logic [NL-1:0] mask, input int abort_sel, input int rst_layer,
                           input bit mux_fix, input bit chk_dwell);
        int s, k, er, f, w, a, last, rst_cyc, first_gap, d;
        bit stop, did_rst;
        logic [NL-1:0] nb;
        s = 2; k = 3; a = -1; rst_cyc = -1; first_gap = -1; stop = 0; last = k + 1;
        for (int t = 0; t < N; t++) begin
            e_en[t] = '0; e_busy[t] = 0; e_done[t] = 0; e_run[t] = 0;
            e_to[t] = (t >= k) ? 1'b0 : model_to;
            e_cur[t] = model_cur;
        end
        for (int l = 0; l < NL; l++) begin
            fin_st[l] = 1 << 30; er_of[l] = -1; en_cnt[l] = 0;
        end
        er = k + 1;
        if (mask == '0) e_done[k+1] = 1;
        for (int l = 0; l < NL && !stop; l++) begin
            if (mask[l]) begin
                er_of[l] = er;
                for (int t = er - 1; t < N; t++) e_cur[t] = l;
                d = (d_cfg[l] == RAND) ? int'($urandom_range(120, 0)) : d_cfg[l];
                fin_st[l] = (d == STALE) ? -100 : er + d;
                f = (er + MD > fin_st[l] + 1) ? er + MD : fin_st[l] + 1;
                if (f > er - 1 + T) begin
                    w = er - 1 + T;
                    for (int t = er; t < w; t++) e_en[t][l] = 1'b1;
                    for (int t = er - 1; t < w; t++) begin e_busy[t] = 1; e_run[t] = 1; end
                    for (int t = w; t < N; t++) e_to[t] = 1;
                    last = w; stop = 1;
                end else begin
                    for (int t = er; t <= f; t++) e_en[t][l] = 1'b1;
                    for (int t = er - 1; t < f; t++) e_run[t] = 1;
                    for (int t = er - 1; t < f + G; t++) e_busy[t] = 1;
                    if (first_gap < 0) first_gap = f;
                    last = f + G + 1;
                    er = f + 1 + G;
                end
            end
        end
        if (mask != '0 && !stop) e_done[last] = 1;
        if (abort_sel == -2) a = (first_gap >= 0) ? first_gap + 1 : -1;
        else a = abort_sel;
        if (a > k) begin
            for (int t = a; t < N; t++) begin
                e_en[t] = '0; e_busy[t] = 0; e_run[t] = 0; e_done[t] = 0;
                e_to[t] = e_to[a-1]; e_cur[t] = e_cur[a-1];
            end
            if (a > last) last = a;
        end
        if (rst_layer >= 0 && er_of[rst_layer] > 0) rst_cyc = er_of[rst_layer] + 3;

        did_rst = 0;
        for (int t = 0; t <= last + 4 && !did_rst; t++) begin
            @(posedge clk);
            #1;
            start = (t == s);
            layer_mask = (t == s) ? mask : NL'($urandom);
            abort = (t == a - 1);
            nb = NL'($urandom);
            for (int l = 0; l < NL; l++) layer_finish[l] = mask[l] ? (t >= fin_st[l]) : nb[l];
            lyr_bw_ena    = NL'($urandom);
            lyr_res_ena   = NL'($urandom);
            lyr_res_wea   = NL'($urandom);
            lyr_bw_addra  = (NL*BW)'({$urandom, $urandom, $urandom, $urandom});
            lyr_res_addra = (NL*RW)'({$urandom, $urandom, $urandom});
            lyr_res_dina  = (NL*DS)'({$urandom, $urandom, $urandom, $urandom});
            if (mux_fix) begin
                lyr_bw_ena[3] = 1'b1;
                lyr_res_ena[3] = 1'b1;
                lyr_res_wea[3] = 1'b1;
                lyr_bw_addra[3*BW +: BW] = 16'd2572;
                lyr_res_addra[3*RW +: RW] = 13'd7880;
            end
            if (t == rst_cyc) begin
                #2 rst = 1'b0;
                #1 chk_zero("arst");
                did_rst = 1;
            end else begin
                @(negedge clk);
                chk_cycle(t);
                for (int l = 0; l < NL; l++) if (layer_en[l]) en_cnt[l]++;
            end
        end
        start = 1'b0;
        abort = 1'b0;
        if (did_rst) begin
            @(posedge clk);
            #1 rst = 1'b1;
            model_cur = 0;
            model_to = 1'b0;
        end else begin
            model_cur = e_cur[last+4];
            model_to = e_to[last+4];
            if (chk_dwell) begin
                for (int l = 0; l < NL; l++) if (mask[l]) chk("dwell_len", 32'(en_cnt[l]), 32'(MD + 1));
            end
        end
    endtask

    task automatic set_d(input int v);
        for (int l = 0; l < NL; l++) d_cfg[l] = v;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_time_limit: got expired want finished");
        $fatal(1, "time limit");
    end

    initial begin
        rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_zero("reset");
        @(posedge clk);
        #1 rst = 1'b1;

        set_d(50);    run_scn(7'h7F, -1, -1, 0, 0);        // full run
        set_d(RAND);  run_scn(7'b0010101, -1, -1, 0, 0);   // skip layers
        set_d(STALE); run_scn(7'h7F, -1, -1, 0, 1);        // stale finish flags
        set_d(RAND);  run_scn(7'b0001100, -1, -1, 1, 0);   // BRAM mux, layer 3 fixed values
        set_d(NEVER); d_cfg[0] = 98;                       // finish on the watchdog edge wins
        run_scn(7'b0000011, -1, -1, 0, 0);                 // layer 1 never finishes
        set_d(RAND);  run_scn(7'h00, -1, -1, 0, 0);        // empty mask, clears timeout
        set_d(99);    run_scn(7'b1000000, -1, -1, 0, 0);   // one cycle past the watchdog
        set_d(10);    run_scn(7'h7F, -1, 5, 0, 0);         // async reset inside layer 5
        set_d(RAND);  run_scn(7'h7F, -2, -1, 0, 0);        // abort in the first gap
        for (int r = 0; r < 8; r++) begin
            for (int l = 0; l < NL; l++) d_cfg[l] = ($urandom_range(9, 0) == 0) ? STALE : RAND;
            run_scn(NL'($urandom), ($urandom_range(2, 0) == 0) ? int'($urandom_range(400, 4)) : -1,
                    -1, r[0], 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/lenet_layer_scheduler.md
# lenet_layer_scheduler

Top-level sequencer for the LeNet-5 layer engines (conv_1, pool_1, conv_2, pool_2, conv_3, fc_1, fc_2). It enables one layer engine at a time, waits for that engine's finish flag, and inserts a quiet gap before the next layer. It multiplexes the active engine's ports onto the single shared bias/weights BRAM port and the single shared result BRAM port. It also provides layer skipping, abort and a per-layer watchdog.

## Interface
- NUM_LAYERS, 7, number of layer engines; index 0 runs first.
- DATA_SIZE, 16, BRAM data width.
- BW_AW, 16, bias/weights BRAM address width.
- RES_AW, 13, result BRAM address width.
- GAP_CYCLES, 2, idle cycles between layers (≥1).
- MIN_DWELL, 2, cycles after enable before the finish flag is trusted.
- TIMEOUT_CYCLES, 2^24, maximum run cycles per layer; 0 disables the watchdog.

- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  level; sampled only in IDLE.
- abort  in  1  level; any state → IDLE.
- layer_mask  in  NUM_LAYERS  bit i=1 runs layer i; latched on accepted start.
- layer_finish  in  NUM_LAYERS  per-engine finish flags.
- lyr_bw_ena  in  NUM_LAYERS  per-engine bias/weights BRAM enable.
- lyr_bw_addra  in  NUM_LAYERS*BW_AW  per-engine bias/weights BRAM address, packed, layer i at [i*BW_AW +: BW_AW].
- lyr_res_ena, lyr_res_wea  in  NUM_LAYERS  per-engine result BRAM enable and write enable.
- lyr_res_addra  in  NUM_LAYERS*RES_AW  per-engine result BRAM address, packed.
- lyr_res_dina  in  NUM_LAYERS*DATA_SIZE  per-engine result BRAM write data, packed.
- layer_en  out  NUM_LAYERS  one-hot-or-zero engine enables.
- bias_weights_bram_ena  out  1  shared bias/weights BRAM enable.
- bias_weights_bram_addra  out  BW_AW  shared bias/weights BRAM address.
- result_bram_ena, result_bram_wea  out  1  shared result BRAM enable and write enable.
- result_bram_addra  out  RES_AW  shared result BRAM address.
- result_bram_dina  out  DATA_SIZE  shared result BRAM write data.
- busy  out  1  high in RUN and GAP.
- done  out  1  one-cycle pulse when the run completes.
- timeout  out  1  sticky; cleared on the next accepted start or on reset.
- cur_layer  out  log2(NUM_LAYERS) width, ceiling  index of the active or last active layer.

## Operation
- States: IDLE, RUN, GAP, DONE.
- Registers: mask_q, cur_layer, dwell_cnt, gap_cnt, run_cnt (32-bit).
- Next layer: the lowest i > cur_layer with mask_q[i]=1. First layer: the lowest i with mask_q[i]=1.
- IDLE: on start=1, latch mask_q, clear timeout, then:
  - mask all zero → DONE;
  - otherwise cur_layer = first layer → RUN.
- RUN:
  - layer_en[cur_layer]=1 registered; all other bits 0.
  - dwell_cnt counts up to MIN_DWELL; run_cnt increments every cycle.
  - Once dwell_cnt = MIN_DWELL and layer_finish[cur_layer]=1: clear layer_en, go to GAP.
  - Finish flags from non-active layers are ignored.
- GAP:
  - layer_en all 0; gap_cnt counts GAP_CYCLES.
  - At expiry: next layer exists → cur_layer = next, clear counters → RUN; none → DONE.
- DONE: done=1 for one cycle → IDLE.
- Watchdog: in RUN, run_cnt = TIMEOUT_CYCLES−1 with no finish → set timeout, clear layer_en → IDLE. No done pulse.
- abort=1 (any state) → IDLE next edge; layer_en=0; no done pulse; mask_q is kept.
- BRAM mux: combinational from the registered cur_layer, gated by state==RUN.
  - In RUN, every shared output equals the cur_layer slice of the corresponding lyr_* input.
  - Outside RUN: all enables 0; addresses and data 0.
  - Engines must hold their BRAM requests low while their enable is low. The mux gating guarantees no overlap even if they do not.
- Read data (douta) is fanned out to all engines outside this block.
- Engines hold state when enable is low, and their finish flag is undefined until first enabled; MIN_DWELL masks a stale or X flag.

## Timing
- Reset values: layer_en=0, all BRAM outputs 0, busy=0, done=0, timeout=0, cur_layer=0, state IDLE.
- start high at edge k → layer_en[first] high after edge k+1.
- Finish seen at edge f (dwell satisfied) → layer_en low after f+1; the engine sees at most one extra enabled cycle.
- Next layer's enable rises after edge f+1+GAP_CYCLES.
- Last layer's finish at edge f → done high for the cycle after f+1+GAP_CYCLES.
- start held high through DONE → a new run begins from IDLE. There is no back-to-back start inside DONE.
- abort and finish on the same edge → abort wins.
- Timeout and finish on the same edge → finish wins.

## Test plan
- Full run, mask=7'h7F, each engine asserts finish 50 cycles after its enable → layer_en walks 0..6 one-hot, gaps of 2 cycles, a single done pulse, busy low after done.
- Skip, mask=7'b0010101 → only layers 0, 2 and 4 are enabled; cur_layer sequence 0, 2, 4; done after layer 4.
- Stale finish: layer_finish=all ones before start → each layer runs exactly MIN_DWELL+1 cycles, never 0.
- BRAM mux: layer 3 drives bw_addra=2572 and res_addra=7880 with wea=1 while layer 2 drives garbage → shared ports show layer 3's values only during its RUN, and are 0 during GAP.
- Watchdog with TIMEOUT_CYCLES=100 and layer 1 never finishing → timeout=1 and layer_en=0 after 100 RUN cycles, state IDLE, no done.
- Reset and abort: drive rst low mid-RUN of layer 5 → all outputs 0 immediately (asynchronous). Then abort asserted in GAP → IDLE, no done.
